// File: rtl/sarlock_key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sarlock_key_load_ctrl
// Description : Loads an 8-bit SARLock key serially into the key-locked c432
//               netlist, runs a single self-test vector against a golden
//               response and releases functional mode only on a match.
//               Optional LOCKOUT_EN macro: permanent lockout after MAX_FAIL
//               failed checks (exit by rst only).
// Revision    : 1.0 - initial release
// ============================================================================
module sarlock_key_load_ctrl #(
    parameter int                KEY_W    = 8,
    parameter int                IN_W     = 36,
    parameter int                OUT_W    = 7,
    parameter logic [IN_W-1:0]   TEST_VEC = 36'h0_0000_00B3,
    parameter logic [OUT_W-1:0]  EXP_RESP = 7'h00,
    parameter int                SETTLE   = 2,
    parameter int                MAX_FAIL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              key_bit_i,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    output logic [KEY_W-1:0]  key_o,
    output logic              test_mode_o,
    output logic [IN_W-1:0]   test_vec_o,
    input  logic [OUT_W-1:0]  dut_resp_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [3:0]        fail_cnt_o
);

    localparam int               CNT_W         = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] c_last_bit    = CNT_W'(KEY_W - 1);
    localparam logic [3:0]       c_settle_load = 4'(SETTLE - 1);
`ifdef LOCKOUT_EN
    localparam logic [3:0]       c_max_fail    = 4'(MAX_FAIL);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CHECK   = 3'd3,
        S_ACTIVE  = 3'd4,
        S_FAIL    = 3'd5,
        S_LOCKOUT = 3'd6
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [KEY_W-1:0]  r_shadow;
    logic [3:0]        r_settle_cnt;
    logic [KEY_W-1:0]  r_key;
    logic              r_ready;
    logic              r_test_mode;
    logic [IN_W-1:0]   r_test_vec;
    logic              r_busy;
    logic              r_pass;
    logic              r_fail;
    logic [3:0]        r_fail_cnt;

    logic              w_accept;
    logic [KEY_W-1:0]  w_shadow_next;
    logic [3:0]        w_fail_cnt_inc;

    assign w_accept       = key_valid_i & r_ready;
    assign w_fail_cnt_inc = (r_fail_cnt == 4'hF) ? r_fail_cnt : r_fail_cnt + 4'd1;

    // Shadow including the bit on the bus, so the final accept can publish the full key
    always_comb begin
        w_shadow_next            = r_shadow;
        w_shadow_next[r_bit_cnt] = key_bit_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shadow     <= '0;
            r_settle_cnt <= '0;
            r_key        <= '0;
            r_ready      <= 1'b0;
            r_test_mode  <= 1'b1;
            r_test_vec   <= '0;
            r_busy       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_ACTIVE, S_FAIL: begin
                    // key_o keeps its previous value until the new key is complete
                    if (start_i) begin
                        r_state     <= S_SHIFT;
                        r_bit_cnt   <= '0;
                        r_shadow    <= '0;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_test_mode <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (w_accept) begin
                        r_shadow  <= w_shadow_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_key        <= w_shadow_next;
                            r_ready      <= 1'b0;
                            r_test_vec   <= TEST_VEC;
                            r_settle_cnt <= c_settle_load;
                            r_state      <= S_SETTLE;
                        end
                    end
                end

                S_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end

                S_CHECK: begin
                    r_busy <= 1'b0;
                    if (dut_resp_i == EXP_RESP) begin
                        r_pass      <= 1'b1;
                        r_test_mode <= 1'b0;
                        r_test_vec  <= '0;
                        r_state     <= S_ACTIVE;
                    end else begin
                        r_fail      <= 1'b1;
                        r_key       <= '0;
                        r_test_mode <= 1'b1;
                        r_fail_cnt  <= w_fail_cnt_inc;
`ifdef LOCKOUT_EN
                        r_state     <= (w_fail_cnt_inc >= c_max_fail) ? S_LOCKOUT : S_FAIL;
`else
                        r_state     <= S_FAIL;
`endif
                    end
                end

`ifdef LOCKOUT_EN
                S_LOCKOUT: begin
                    r_key       <= '0;
                    r_test_mode <= 1'b1;
                    r_fail      <= 1'b1;
                    r_ready     <= 1'b0;
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign key_ready_o = r_ready;
    assign key_o       = r_key;
    assign test_mode_o = r_test_mode;
    assign test_vec_o  = r_test_vec;
    assign busy_o      = r_busy;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign fail_cnt_o  = r_fail_cnt;

endmodule
`default_nettype wire
